// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
package piso_pkg;

    // Default parallel word width.
    localparam int DEFAULT_WIDTH = 4;

    // Transmitter FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_if.sv
// Load handshake and serial output bundle of the transmitter.
interface piso_if
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             busy;

    // Producer / consumer side (drives words and shift enable).
    modport master (
        output din, load_valid, shift_en,
        input  load_ready, sout, sout_valid, sout_first, sout_last, busy
    );

    // Transmitter side.
    modport slave (
        input  din, load_valid, shift_en,
        output load_ready, sout, sout_valid, sout_first, sout_last, busy
    );

endinterface

// File: rtl/piso_bit_cnt.sv
// Bit position counter for one word: synchronous clear, count enable and
// a terminal-count flag raised on the word's last bit position.
module piso_bit_cnt #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Counter register: reset and clear win over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == LAST_POS);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter: accepts a WIDTH-bit word through a
// valid/ready handshake and emits it MSB first, one bit per enabled cycle,
// with first/last markers and gapless back-to-back words.
module piso_tx
    import piso_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic    clk,
    input  logic    rst,
    piso_if.slave   bus
);

    // Counter value at which the next shift lands on the last bit.
    localparam logic [CNT_W-1:0] PENULT_POS = CNT_W'(WIDTH - 2);

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             sout_valid_reg;
    logic             sout_first_reg;
    logic             sout_last_reg;

    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             in_shift;
    logic             last_step;
    logic             load_ready;
    logic             accept;

    assign in_shift  = (state_reg == SHIFT);
    // Last bit is being consumed this cycle, so the slot frees up.
    assign last_step = in_shift && cnt_tc && bus.shift_en;

    assign load_ready = !rst && (!in_shift || last_step);
    assign accept     = bus.load_valid && load_ready;

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept || last_step),
        .en  (in_shift && bus.shift_en && !cnt_tc),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // FSM, shift register and registered serial markers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            sout_valid_reg <= 1'b0;
            sout_first_reg <= 1'b0;
            sout_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg      <= SHIFT;
                        shift_reg      <= bus.din;
                        sout_valid_reg <= 1'b1;
                        sout_first_reg <= 1'b1;
                        sout_last_reg  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.shift_en) begin
                        if (cnt_tc) begin
                            if (accept) begin
                                // Next word follows without a gap.
                                shift_reg      <= bus.din;
                                sout_valid_reg <= 1'b1;
                                sout_first_reg <= 1'b1;
                                sout_last_reg  <= 1'b0;
                            end else begin
                                state_reg      <= IDLE;
                                shift_reg      <= '0;
                                sout_valid_reg <= 1'b0;
                                sout_first_reg <= 1'b0;
                                sout_last_reg  <= 1'b0;
                            end
                        end else begin
                            shift_reg      <= {shift_reg[WIDTH-2:0], 1'b0};
                            sout_first_reg <= 1'b0;
                            sout_last_reg  <= (cnt == PENULT_POS);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Shift register is zero outside SHIFT, so its MSB is a valid idle sout.
    assign bus.sout       = shift_reg[WIDTH-1];
    assign bus.sout_valid = sout_valid_reg;
    assign bus.sout_first = sout_first_reg;
    assign bus.sout_last  = sout_last_reg;
    assign bus.busy       = in_shift;
    assign bus.load_ready = load_ready;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a directed table of cycles with hand-written expected
// outputs, a bit-queue reference model compared every cycle, and a serial
// loopback that rebuilds each word from sout.
module tb_piso_tx;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;

    piso_if #(.WIDTH(WIDTH)) bus ();

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // One directed cycle: inputs applied for the cycle, expected
    // {load_ready, sout, sout_valid, sout_first, sout_last, busy}.
    typedef struct {
        logic             r;
        logic             lv;
        logic [WIDTH-1:0] d;
        logic             se;
        logic [5:0]       e;
    } row_t;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } bit_t;

    row_t             rows [$];
    bit_t             bitq [$];
    logic [WIDTH-1:0] words [$];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         lb_checks = 0;
    logic       lit_en = 1'b0;
    int         lit_row = 0;
    logic [5:0] lit_exp = '0;
    logic       final_chk = 1'b0;

    task automatic apply(input row_t rw);
        rst            = rw.r;
        bus.load_valid = rw.lv;
        bus.din        = rw.d;
        bus.shift_en   = rw.se;
    endtask

    // Reference model and every comparison live in this one process.
    initial begin : monitor
        logic [WIDTH-1:0] lb_word;
        bit                final_done;
        lb_word    = '0;
        final_done = 1'b0;
        forever begin
            @(posedge clk);
            // Model update: a word becomes WIDTH queued bits; each enabled
            // edge consumes the bit on display.
            begin
                bit   acc;
                bit_t dropped;
                if (rst) begin
                    bitq.delete();
                    words.delete();
                end else begin
                    acc = bus.load_valid &&
                          (bitq.size() == 0 || (bitq.size() == 1 && bus.shift_en));
                    if (bus.shift_en && bitq.size() > 0) dropped = bitq.pop_front();
                    if (acc) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            bitq.push_back('{b: bus.din[WIDTH-1-i], f: (i == 0),
                                             l: (i == WIDTH-1)});
                        end
                        words.push_back(bus.din);
                    end
                end
            end
            @(negedge clk);
            begin
                logic [5:0]       got;
                logic [5:0]       expv;
                logic             exp_ready;
                logic [WIDTH-1:0] exp_word;
                got = {bus.load_ready, bus.sout, bus.sout_valid,
                       bus.sout_first, bus.sout_last, bus.busy};
                exp_ready = !rst && (bitq.size() == 0 ||
                                     (bitq.size() == 1 && bus.shift_en));
                if (bitq.size() > 0)
                    expv = {exp_ready, bitq[0].b, 1'b1, bitq[0].f, bitq[0].l, 1'b1};
                else
                    expv = {exp_ready, 5'b00000};
                n_cmp++;
                if (got !== expv) begin
                    n_bad++;
                    $display("FAIL model t=%0t rdy/sout/vld/first/last/busy got %b required %b",
                             $time, got, expv);
                end
                if (lit_en) begin
                    n_cmp++;
                    if (got !== lit_exp) begin
                        n_bad++;
                        $display("FAIL row%0d rdy/sout/vld/first/last/busy got %b required %b",
                                 lit_row, got, lit_exp);
                    end
                end
                // Loopback: rebuild the word from bits that are consumed.
                if (bus.sout_valid === 1'b1 && bus.shift_en) begin
                    lb_word = {lb_word[WIDTH-2:0], bus.sout};
                    if (bus.sout_last === 1'b1) begin
                        exp_word = (words.size() > 0) ? words.pop_front() : 'x;
                        n_cmp++;
                        lb_checks++;
                        if (lb_word !== exp_word) begin
                            n_bad++;
                            $display("FAIL loopback word got %b required %b", lb_word, exp_word);
                        end
                    end
                end
                if (final_chk && !final_done) begin
                    final_done = 1'b1;
                    n_cmp++;
                    if (lb_checks < 1000) begin
                        n_bad++;
                        $display("FAIL loopback_count got %0d required >= 1000", lb_checks);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin : stim
        //                 rst   lv    din      se    rdy,sout,vld,first,last,busy
        rows.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 6'b000000}); // 0 pre-edge, unchecked
        rows.push_back('{1'b1, 1'b1, 4'b1111, 1'b1, 6'b000000}); // 1 in reset
        rows.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, 6'b100000}); // 2 ready after reset, load
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011101}); // 3 bit 1 first
        rows.push_back('{1'b0, 1'b0, 4'b1111, 1'b1, 6'b001001}); // 4 bit 0
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011001}); // 5 bit 1
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b111011}); // 6 bit 1 last
        rows.push_back('{1'b0, 1'b1, 4'b1011, 1'b1, 6'b100000}); // 7 idle, load
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011101}); // 8
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b001001}); // 9
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011001}); // 10
        rows.push_back('{1'b0, 1'b1, 4'b0110, 1'b1, 6'b111011}); // 11 last, load next
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b001101}); // 12 bit 0 first
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011001}); // 13
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011001}); // 14
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b101011}); // 15 bit 0 last
        rows.push_back('{1'b0, 1'b1, 4'b1001, 1'b1, 6'b100000}); // 16 idle, load
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011101}); // 17 bit 1 first
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 6'b001001}); // 18 bit 0, stall
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 6'b001001}); // 19 stall
        rows.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 6'b001001}); // 20 resume, not ready
        rows.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 6'b001001}); // 21 bit 0, not ready
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b111011}); // 22 bit 1 last
        rows.push_back('{1'b0, 1'b1, 4'b1110, 1'b1, 6'b100000}); // 23 idle, load
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011101}); // 24 bit 1 first
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011001}); // 25 bit 1
        rows.push_back('{1'b1, 1'b1, 4'b0101, 1'b1, 6'b011001}); // 26 reset mid-word
        rows.push_back('{1'b0, 1'b1, 4'b1100, 1'b1, 6'b100000}); // 27 idle, load
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011101}); // 28 bit 1 first
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b011001}); // 29 bit 1
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b001001}); // 30 bit 0
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b101011}); // 31 bit 0 last
        rows.push_back('{1'b0, 1'b0, 4'b0000, 1'b1, 6'b100000}); // 32 idle

        apply(rows[0]);
        for (int i = 1; i < rows.size(); i++) begin
            @(posedge clk);
            #1;
            apply(rows[i]);
            lit_row = i;
            lit_exp = rows[i].e;
            lit_en  = 1'b1;
        end
        @(posedge clk);
        #1;
        lit_en = 1'b0;

        // Continuous random words, gapless.
        for (int c = 0; c < 4 * 1000 + 8; c++) begin
            rst            = 1'b0;
            bus.load_valid = 1'b1;
            bus.shift_en   = 1'b1;
            bus.din        = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end

        // Random handshake and stalls.
        for (int c = 0; c < 400; c++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.shift_en   = ($urandom_range(0, 3) != 0);
            bus.din        = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end

        // Drain.
        bus.load_valid = 1'b0;
        bus.shift_en   = 1'b1;
        for (int c = 0; c < 2 * WIDTH; c++) begin
            @(posedge clk);
            #1;
        end
        final_chk = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH SHALL have default 4 and set the parallel word width; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 din  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
REQ-005 load_valid  input  1  producer asserts when din holds a word to send.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 shift_en  input  1  shift enable; low SHALL stall serialization with all outputs held.
REQ-008 sout  output  1  serial data, MSB first.
REQ-009 sout_valid  output  1  sout carries a valid bit this cycle.
REQ-010 sout_first  output  1  high with the first (MSB) bit of each word.
REQ-011 sout_last  output  1  high with the last (LSB) bit of each word.
REQ-012 busy  output  1  a word is being serialized.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 Load accept SHALL occur at a rising edge where load_valid=1 and load_ready=1; din SHALL then be captured into a WIDTH-bit shift register.
REQ-015 load_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when the bit counter = WIDTH-1 and shift_en=1; otherwise 0; forced 0 while rst=1.
REQ-016 Accept in IDLE: the next cycle SHALL enter SHIFT with sout=din[WIDTH-1], sout_valid=1, sout_first=1, busy=1, counter=0.
REQ-017 In SHIFT with shift_en=1, each edge SHALL shift the register left by one, with zero fill, and increment the counter; sout SHALL always equal the register MSB.
REQ-018 In SHIFT with shift_en=0, register, counter, sout, sout_valid, sout_first and sout_last SHALL hold unchanged.
REQ-019 sout_last SHALL be 1 exactly when the counter = WIDTH-1 in SHIFT; sout_first exactly when the counter = 0.
REQ-020 Latency: with shift_en held high, bits SHALL appear on cycles T+1..T+WIDTH after an accept at edge T.
REQ-021 Last bit with shift_en=1 and no accept: the next cycle SHALL be IDLE with sout=0, sout_valid=0, busy=0.
REQ-022 Last bit with shift_en=1 and a simultaneous accept: the next cycle SHALL present the new word's MSB with sout_first=1, giving gapless back-to-back words.
REQ-023 In IDLE, sout SHALL be 0 and sout_valid, sout_first, sout_last and busy SHALL be 0.
REQ-024 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1; there SHALL be no wrap-around within a word.
REQ-025 din changes while not accepted SHALL have no effect.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, shift register=0, counter=0 and all registered outputs=0, overriding any load or shift in that cycle.
REQ-027 Reset mid-word SHALL discard the remaining bits; no partial-word completion.
REQ-028 The first cycle after rst deasserts SHALL show load_ready=1.

Structure
REQ-029 Package piso_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the default WIDTH constant.
REQ-030 The bit counter (clear, enable, terminal-count flag) SHALL be a single sub-module, piso_bit_cnt; the FSM and shift register SHALL remain in piso_tx.

Verification
REQ-031 Reset: rst=1 for 2 cycles with load_valid=1 -> load_ready=0 and all outputs 0 during reset; load_ready=1 on the first cycle after.
REQ-032 Single word: load 4'b1011 at edge T, shift_en=1 -> sout 1,0,1,1 on T+1..T+4; sout_first at T+1, sout_last at T+4; IDLE at T+5.
REQ-033 Back-to-back: load 4'b1011, then 4'b0110 accepted on the last-bit cycle -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; sout_valid never drops.
REQ-034 Stall: load 4'b1001, drop shift_en for 2 cycles after the 2nd bit -> sout holds 0 for 3 cycles; word completes in 6 cycles; load_ready stays 0 until the last bit with shift_en=1.
REQ-035 Reset mid-word: rst after 2 bits of 4'b1110 -> IDLE next cycle, outputs 0; a following load of 4'b1100 serializes as 1,1,0,0.
REQ-036 Loopback: sout feeds a 4-bit serial-in left-shift model enabled by sout_valid -> after sout_last, the model holds the loaded word for random din over 1000 words.
